// File: rtl/router_arbiter.sv
// Round-robin arbiter and flit mux with packet locking and a registered valid/ready output stage.
// Optional watchdog on stalled locked packets: define ROUTER_ARB_TIMEOUT_EN.
module router_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int FLIT_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS-1:0]            req_is_head,
    input  logic [NUM_PORTS-1:0]            req_is_tail,
    input  logic [NUM_PORTS*FLIT_WIDTH-1:0] req_flit,
    output logic [NUM_PORTS-1:0]            req_ready,
    output logic                            out_valid,
    output logic [FLIT_WIDTH-1:0]           out_flit,
    output logic [$clog2(NUM_PORTS)-1:0]    out_port_id,
    input  logic                            out_ready,
    output logic                            timeout_err
);

    localparam int PW = $clog2(NUM_PORTS);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state, state_next;
    logic [PW-1:0]   rr_ptr, locked_port, winner, sel;
    logic [PW:0]     scan_idx;
    logic [NUM_PORTS-1:0] cand;
    logic            found, load, accept;

`ifdef ROUTER_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]   tcnt;
    logic            timeout_fire;
`endif

    // Round-robin scan starting at rr_ptr; only head flits can open a grant.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        cand     = req_valid & req_is_head;
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            scan_idx = {1'b0, rr_ptr} + (PW+1)'(k);
            if (scan_idx >= (PW+1)'(NUM_PORTS))
                scan_idx = scan_idx - (PW+1)'(NUM_PORTS);
            if (!found && cand[scan_idx[PW-1:0]]) begin
                found  = 1'b1;
                winner = scan_idx[PW-1:0];
            end
        end
    end

    always_comb begin
        load       = ~out_valid | out_ready;
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        sel        = locked_port;
`ifdef ROUTER_ARB_TIMEOUT_EN
        timeout_fire = 1'b0;
`endif
        case (state)
            IDLE: begin
                sel = winner;
                if (found && load) begin
                    accept            = 1'b1;
                    req_ready[winner] = 1'b1;
                    if (!req_is_tail[winner])
                        state_next = LOCKED;
                end
            end
            LOCKED: begin
                // A stray head on the locked port is forwarded as an ordinary body flit.
                if (req_valid[locked_port] && load) begin
                    accept                 = 1'b1;
                    req_ready[locked_port] = 1'b1;
                    if (req_is_tail[locked_port])
                        state_next = IDLE;
                end
`ifdef ROUTER_ARB_TIMEOUT_EN
                else if (!req_valid[locked_port] && load &&
                         tcnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_next   = IDLE;
                    timeout_fire = 1'b1;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state       <= IDLE;
            rr_ptr      <= '0;
            locked_port <= '0;
            out_valid   <= 1'b0;
            out_flit    <= '0;
            out_port_id <= '0;
        end else begin
            state <= state_next;
            if (accept && state == IDLE) begin
                locked_port <= winner;
                rr_ptr      <= (winner == PW'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
            end
            if (load) begin
                out_valid <= accept;
                if (accept) begin
                    out_flit    <= req_flit[sel*FLIT_WIDTH +: FLIT_WIDTH];
                    out_port_id <= sel;
                end
            end
        end
    end

`ifdef ROUTER_ARB_TIMEOUT_EN
    // Counts idle cycles of the locked port; output stalls do not count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_fire;
            if (state != LOCKED || accept || timeout_fire)
                tcnt <= '0;
            else if (!req_valid[locked_port] && load)
                tcnt <= tcnt + 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_arbiter.sv
// Self-checking bench for router_arbiter: directed scenarios plus randomized packet traffic
// compared cycle by cycle against a queue-free behavioural model of the arbitration rules.
module tb_router_arbiter;

    localparam int N = 4;
    localparam int W = 64;
    localparam int T = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid, req_is_head, req_is_tail, req_ready;
    logic [N*W-1:0]   req_flit;
    logic             out_valid, out_ready, timeout_err;
    logic [W-1:0]     out_flit;
    logic [1:0]       out_port_id;

    int n_checks = 0;
    int n_fail   = 0;

    router_arbiter #(.NUM_PORTS(N), .FLIT_WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_is_head(req_is_head), .req_is_tail(req_is_tail),
        .req_flit(req_flit), .req_ready(req_ready),
        .out_valid(out_valid), .out_flit(out_flit), .out_port_id(out_port_id),
        .out_ready(out_ready), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: packet-level rules of the arbiter.
    bit           m_locked, m_ov, m_to, m_load;
    int           m_lport, m_ptr, m_id, m_cnt, m_grant;
    logic [W-1:0] m_flit;
    logic [N-1:0] m_ready, last_ready;

    task automatic model_reset();
        m_locked = 0; m_ov = 0; m_to = 0; m_lport = 0; m_ptr = 0;
        m_id = 0; m_cnt = 0; m_grant = -1; m_flit = '0; m_ready = '0;
    endtask

    task automatic model_comb();
        bit got_one;
        m_grant = -1;
        got_one = 0;
        m_load  = !m_ov || out_ready;
        if (m_load) begin
            if (!m_locked) begin
                for (int k = 0; k < N; k++) begin
                    int p;
                    p = (m_ptr + k) % N;
                    if (!got_one && req_valid[p] && req_is_head[p]) begin
                        got_one = 1;
                        m_grant = p;
                    end
                end
            end else if (req_valid[m_lport]) begin
                m_grant = m_lport;
            end
        end
        m_ready = (m_grant >= 0) ? N'(1 << m_grant) : '0;
    endtask

    task automatic model_seq();
        m_to = 0;
        if (m_load) begin
            if (m_grant >= 0) begin
                m_ov   = 1;
                m_flit = req_flit[m_grant*W +: W];
                m_id   = m_grant;
                m_cnt  = 0;
                if (!m_locked) begin
                    m_ptr = (m_grant + 1) % N;
                    if (!req_is_tail[m_grant]) begin
                        m_locked = 1;
                        m_lport  = m_grant;
                    end
                end else if (req_is_tail[m_grant]) begin
                    m_locked = 0;
                end
            end else begin
                m_ov = 0;
            end
        end
`ifdef ROUTER_ARB_TIMEOUT_EN
        if (m_locked && m_grant < 0 && m_load && !req_valid[m_lport]) begin
            m_cnt++;
            if (m_cnt == T) begin
                m_locked = 0;
                m_to     = 1;
                m_cnt    = 0;
            end
        end
`endif
    endtask

    // One clock: inputs already driven; checks req_ready mid-cycle and registered outputs after the edge.
    task automatic cycle();
        #1;
        model_comb();
        last_ready = req_ready;
        check("req_ready", req_ready, m_ready);
        @(posedge clk);
        model_seq();
        #1;
        check("out_valid", out_valid, m_ov);
        check("out_flit", out_flit, m_flit);
        check("out_port_id", out_port_id, m_id);
        check("timeout_err", timeout_err, m_to);
    endtask

    task automatic set_port(input int p, input bit v, input bit h, input bit t, input logic [W-1:0] d);
        req_valid[p]     = v;
        req_is_head[p]   = h;
        req_is_tail[p]   = t;
        req_flit[p*W +: W] = d;
    endtask

    task automatic clear_ports();
        req_valid = '0; req_is_head = '0; req_is_tail = '0; req_flit = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_ports();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Random traffic sources: each port walks through packets of 1..4 flits.
    int pos[N];
    int len[N];

    task automatic src_update();
        for (int p = 0; p < N; p++) begin
            if (m_ready[p]) begin
                pos[p]++;
                if (pos[p] == len[p]) pos[p] = 0;
                req_valid[p] = 1'b0;
            end
            if (m_to && p == m_lport) begin
                pos[p] = 0;
                req_valid[p] = 1'b0;
            end
            if (!req_valid[p] && $urandom_range(0, 99) < 60) begin
                if (pos[p] == 0) len[p] = $urandom_range(1, 4);
                set_port(p, 1'b1, pos[p] == 0, pos[p] == len[p] - 1, {$urandom, $urandom});
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b1;
        clear_ports();
        model_reset();
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_flit", out_flit, 0);
        check("rst_out_port_id", out_port_id, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_req_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two single-flit packets on ports 0 and 2.
        set_port(0, 1, 1, 1, 64'h100);
        set_port(2, 1, 1, 1, 64'h102);
        cycle();
        check("t1_id0", out_port_id, 0);
        check("t1_v0", out_valid, 1);
        set_port(0, 0, 0, 0, 64'h0);
        cycle();
        check("t1_id2", out_port_id, 2);
        check("t1_v1", out_valid, 1);
        set_port(2, 0, 0, 0, 64'h0);
        cycle();
        check("t1_drain", out_valid, 0);

        // Three-flit packet on port 1 holds off a head waiting on port 3.
        set_port(1, 1, 1, 0, 64'hA1);
        cycle();
        check("t2_a1", out_flit, 64'hA1);
        set_port(1, 1, 0, 0, 64'hA2);
        set_port(3, 1, 1, 1, 64'hB1);
        cycle();
        check("t2_a2", out_flit, 64'hA2);
        check("t2_rdy3_a2", last_ready[3], 0);
        set_port(1, 1, 0, 1, 64'hA3);
        cycle();
        check("t2_a3", out_flit, 64'hA3);
        check("t2_id_a3", out_port_id, 1);
        check("t2_rdy3_a3", last_ready[3], 0);
        set_port(1, 0, 0, 0, 64'h0);
        cycle();
        check("t2_b1", out_flit, 64'hB1);
        check("t2_id_b1", out_port_id, 3);
        set_port(3, 0, 0, 0, 64'h0);

        // All ports saturated with single-flit packets.
        for (int p = 0; p < N; p++) set_port(p, 1, 1, 1, 64'h30 + 64'(p));
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("t3_rr_order", out_port_id, 64'(i % N));
        end
        clear_ports();

        // Backpressure holds the output register.
        set_port(0, 1, 1, 1, 64'hDEAD);
        cycle();
        check("t4_load", out_flit, 64'hDEAD);
        set_port(0, 0, 0, 0, 64'h0);
        set_port(1, 1, 1, 1, 64'hBEEF);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t4_hold", out_flit, 64'hDEAD);
            check("t4_no_ready", last_ready, 0);
        end
        out_ready = 1'b1;
        cycle();
        check("t4_release_rdy", last_ready, 4'b0010);
        check("t4_release_flit", out_flit, 64'hBEEF);
        set_port(1, 0, 0, 0, 64'h0);

        // Reset in the middle of a four-flit packet on port 2.
        set_port(2, 1, 1, 0, 64'h200);
        cycle();
        set_port(2, 1, 0, 0, 64'h201);
        cycle();
        check("t5_body", out_flit, 64'h201);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        do_reset();
        set_port(2, 1, 0, 0, 64'h202);
        cycle();
        check("t5_body_blocked", last_ready, 0);
        check("t5_no_out", out_valid, 0);
        set_port(0, 1, 1, 1, 64'h300);
        cycle();
        check("t5_head_rdy", last_ready, 4'b0001);
        check("t5_head_id", out_port_id, 0);
        check("t5_head_flit", out_flit, 64'h300);
        clear_ports();

`ifdef ROUTER_ARB_TIMEOUT_EN
        do_reset();
        set_port(1, 1, 1, 0, 64'h110);
        cycle();
        set_port(1, 0, 0, 0, 64'h0);
        for (int k = 1; k <= 20; k++) begin
            cycle();
            check("t6_pulse", timeout_err, (k == T) ? 1 : 0);
        end
        set_port(0, 1, 1, 1, 64'h120);
        cycle();
        check("t6_regrant_id", out_port_id, 0);
        check("t6_regrant_v", out_valid, 1);
        clear_ports();
`endif

        // Randomized traffic with random backpressure.
        do_reset();
        for (int p = 0; p < N; p++) begin
            pos[p] = 0;
            len[p] = 1;
        end
        for (int i = 0; i < 1500; i++) begin
            src_update();
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/router_arbiter.md
Name: router_arbiter

Overview:
- Round-robin arbiter and flit mux in front of a shared router pipeline stage.
- NUM_PORTS requesters (input queues) compete for one downstream stage.
- A grant is held from a head flit through its tail flit, so packets are never interleaved.
- Output is one register stage with valid/ready handshake toward the router stage.

Parameters:
NUM_PORTS, 4, number of requesting input queues (2..8)
FLIT_WIDTH, 64, flit payload width in bits
TIMEOUT_CYCLES, 16, watchdog limit; used only with ROUTER_ARB_TIMEOUT_EN

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_PORTS  per-port flit valid
req_is_head  input  NUM_PORTS  per-port flit is head of packet
req_is_tail  input  NUM_PORTS  per-port flit is tail (head+tail = single-flit packet)
req_flit  input  NUM_PORTS*FLIT_WIDTH  per-port flit, port i at bits [i*FLIT_WIDTH +: FLIT_WIDTH]
req_ready  output  NUM_PORTS  per-port flit accepted this cycle
out_valid  output  1  output register holds a flit
out_flit  output  FLIT_WIDTH  registered flit
out_port_id  output  $clog2(NUM_PORTS)  source port of out_flit
out_ready  input  1  downstream accepts out_flit
timeout_err  output  1  watchdog pulse (tied 0 without macro)

Behaviour:
- Reset values: out_valid=0, out_flit=0, out_port_id=0, timeout_err=0, state=IDLE, rr_ptr=0, locked_port=0.
- Transfer rule: `load = ~out_valid | out_ready`. A flit moves into the output register only when `load` is 1. req_ready is one-hot or zero; it is never asserted while `load`=0.
- State IDLE:
  - Candidates are ports with req_valid=1 and req_is_head=1. Non-head flits are not granted in IDLE.
  - Winner is the first candidate found scanning rr_ptr, rr_ptr+1, … wrapping modulo NUM_PORTS.
  - If `load` is set: req_ready[winner]=1, flit and id are registered, rr_ptr <= winner+1 (wraps to 0).
  - Head without tail -> LOCKED with locked_port=winner. Head with tail -> stay IDLE.
- State LOCKED:
  - Only locked_port is considered; other ports get req_ready=0 regardless of their valid.
  - If req_valid[locked_port] and `load`: accept the flit.
  - If the accepted flit has is_tail=1 -> IDLE.
  - rr_ptr is unchanged while LOCKED.
- Latency: flit accepted at edge N appears on out_valid/out_flit after edge N, i.e. 1 cycle.
- Throughput: 1 flit/cycle while out_ready=1.
- Backpressure: out_valid=1 and out_ready=0 -> out_flit and out_port_id are held stable, and no req_ready is asserted.
- Head flit arriving while LOCKED on a different port: waits; no effect on state.
- Head flit on locked_port while LOCKED (protocol error): treated as a body flit, no state change.
- No requests in IDLE: out_valid drops after the current flit is consumed.
- Reset asserted mid-packet: immediate return to IDLE, out_valid=0, partial packet dropped; the next grant requires a head flit.

Optional Feature:
ROUTER_ARB_TIMEOUT_EN
- Defined:
  - A counter runs only in LOCKED. It is cleared on every accepted flit and on entry to LOCKED.
  - It increments each cycle req_valid[locked_port]=0.
  - At TIMEOUT_CYCLES: state -> IDLE, timeout_err=1 for exactly one cycle, counter cleared. The abandoned packet is not forwarded further.
  - Backpressure (out_ready=0) does not increment the counter.
- Not defined: no counter logic; timeout_err is a constant 0; LOCKED waits indefinitely.

Test Plan:
- Reset, then ports 0 and 2 both present single-flit packets (head=tail=1), out_ready=1 -> out_port_id 0 then 2 on consecutive cycles, out_valid=1 for 2 cycles.
- Port 1 sends a 3-flit packet A1,A2,A3 while port 3 holds head B1 valid -> out sequence A1,A2,A3,B1, out_port_id 1,1,1,3; req_ready[3]=0 until A3 is accepted.
- All 4 ports continuously present single-flit packets for 8 cycles -> grant order 0,1,2,3,0,1,2,3.
- out_ready=0 for 3 cycles with out_valid=1 and flit 0xDEAD -> out_flit held at 0xDEAD, all req_ready=0; on release, the next flit appears the following cycle.
- rst_n pulsed low during the body of a 4-flit packet on port 2 -> out_valid=0 immediately; after reset, a body flit on port 2 is not granted, and a head flit on port 0 is granted.
- With ROUTER_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: port 1 head only, then silent -> timeout_err pulses high one cycle, 16 cycles after the head is accepted; a port 0 head is granted next.
